uartx: RTL and testbench
========================

# uartx

Parametrised full-duplex UART successor with a runtime baud divisor, 16x oversampling with majority-vote sampling, configurable parity and stop bits, and per-frame error reporting. Byte traffic crosses valid/ready streams backed by internal TX and RX FIFOs, so the block sits between a bus-facing register wrapper and the pins. It supersedes the fixed-rate, bus-coupled UART in COM.

## Interface
- DATA_, 8: data bits per frame, 5..9
- DEPTH_, 4: log2 of each FIFO depth; 16 entries
- DIV_, 16: width of cfg_div
- DIV_RST, 1: cfg_div reset-time default, used until cfg_load
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cfg_div  in  DIV_  clocks per oversample tick minus 1
- cfg_par  in  2  00 none, 01 even, 10 odd, 11 treated as none
- cfg_stop2  in  1  two stop bits when 1
- cfg_load  in  1  latch cfg_* into the active config; ignored unless both engines are idle
- tx_data  in  DATA_  byte to send
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_  received byte
- rx_perr  out  1  parity error for rx_data
- rx_ferr  out  1  framing error (stop bit sampled low) for rx_data
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops
- rx_ovf  out  1  sticky: a frame was dropped on a full RX FIFO
- ovf_clr  in  1  clears rx_ovf
- busy  out  1  TX or RX engine not idle
- rx  in  1  serial input, asynchronous
- tx  out  1  serial output

## Operation
- Tick generator: counter reloads from active div and emits a 1-cycle tick every div+1 clocks. Free-running; restarts only on rst.
- rx passes through a 2-flop synchroniser (reset value 1).
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on synchronised rx == 0; the tick sub-counter is cleared.
  - Sample point for each bit is the majority of ticks 7, 8 and 9 of that bit.
  - START: if the sample is 1, the start is a glitch; return to IDLE with no push.
  - DATA: DATA_ samples, LSB first.
  - PARITY: entered only when parity is enabled. perr = mismatch.
  - STOP: 1 or 2 stop samples; ferr if any stop sample is 0.
  - At the end of STOP: push {ferr, perr, data}. If the FIFO is full, drop the frame and set rx_ovf. Return to IDLE. After a framing error, IDLE waits for rx == 1 before arming again.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE with the FIFO non-empty, pop and begin a frame aligned to the next tick.
  - Each bit lasts 16 ticks. Order: start 0, data LSB first, optional parity, stop bit(s) 1. Back-to-back frames carry no idle gap.
- FIFO push and pop in the same cycle are permitted at any fill level, including full.
- ovf_clr has priority over a simultaneous overflow set.

## Timing
- Reset values: tx = 1, tx_ready = 1, rx_valid = 0, rx_data/rx_perr/rx_ferr = 0, rx_ovf = 0, busy = 0. The active config is loaded from DIV_RST, no parity, 1 stop bit. Both FIFOs are emptied.
- rst mid-frame aborts both engines. tx goes to 1 the cycle after rst is asserted.
- TX FIFO write to first tx falling edge: at most 3 + (div+1) clocks.
- rx_data is first-word-fall-through. rx_valid rises 1 cycle after the STOP sample tick.
- tx_ready deasserts in the cycle after the write that fills the FIFO.
- cfg_div = 0 gives one tick per clock, which is the legal minimum.

## Structure
- Add to pkg:
  - uart_par_t enum (NONE, EVEN, ODD)
  - the OVS = 16 constant
  - sample tick indices 7/8/9
- Sub-module uartx_fifo: synchronous FWFT FIFO with active-high rst, parametrised by width and DEPTH_. Instantiate it twice, with width DATA_ for TX and DATA_+2 for RX.
- The tick generator and both FSMs live in uartx.

## Test plan
- Loopback (tx tied to rx), div = 0, 8N1: write 0x00, 0xA5, 0xFF -> the same three bytes on rx_data, perr = ferr = 0. Each frame is 160 clocks, with no gap between frames.
- cfg_par = even, cfg_stop2 = 1: send 0x07 -> tx parity bit 1, two stop bits. Inject a flipped parity bit on rx -> rx_perr = 1 alongside 0x07.
- Drive rx low for 5 ticks, then high -> no push, engine back in IDLE, busy = 0.
- Hold rx low through the stop bit -> rx_ferr = 1, data 0x00. A new start edge is ignored until rx returns high.
- rx_ready held 0 while 17 frames arrive -> 16 entries kept, 17th dropped, rx_ovf = 1. ovf_clr pulse -> rx_ovf = 0.
- Assert rst mid-frame during TX data bits -> tx = 1 next cycle, tx_ready = 1, FIFO empty.

Source files
------------

// File: rtl/uartx_pkg.sv
// Shared types and constants for the uartx UART: parity modes, engine states,
// oversampling ratio and the majority-vote sample tick indices.
package uartx_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } uart_par_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  localparam int OVS = 16;
  localparam logic [3:0] SAMP_A    = 4'd7;
  localparam logic [3:0] SAMP_B    = 4'd8;
  localparam logic [3:0] SAMP_C    = 4'd9;
  localparam logic [3:0] TICK_LAST = 4'(OVS - 1);

  // Parity bit for a data word whose XOR-reduction is ones_xor.
  function automatic logic par_of(input logic odd, input logic ones_xor);
    return odd ? ~ones_xor : ones_xor;
  endfunction

endpackage

// File: rtl/uartx_fifo.sv
// Synchronous first-word-fall-through FIFO, 2**DEPTH_ entries. A push is
// accepted when full if a pop happens in the same cycle; rdata reads 0 when empty.
module uartx_fifo #(
  parameter int W      = 8,
  parameter int DEPTH_ = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] wdata,
  input  logic         push,
  output logic         full,
  output logic [W-1:0] rdata,
  input  logic         pop,
  output logic         empty
);

  localparam int N = 1 << DEPTH_;
  localparam logic [DEPTH_:0] FULL_CNT = {1'b1, {DEPTH_{1'b0}}};

  logic [W-1:0]      mem [N];
  logic [DEPTH_-1:0] wptr;
  logic [DEPTH_-1:0] rptr;
  logic [DEPTH_:0]   count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uartx.sv
// Full-duplex UART: runtime baud divisor, 16x oversampled majority-vote receiver,
// configurable parity/stop bits, FIFO-backed valid/ready byte streams.
module uartx
  import uartx_pkg::*;
#(
  parameter int          DATA_   = 8,
  parameter int          DEPTH_  = 4,
  parameter int          DIV_    = 16,
  parameter int unsigned DIV_RST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DIV_-1:0] cfg_div,
  input  logic [1:0]      cfg_par,
  input  logic            cfg_stop2,
  input  logic            cfg_load,
  input  logic [DATA_-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DATA_-1:0] rx_data,
  output logic            rx_perr,
  output logic            rx_ferr,
  output logic            rx_valid,
  input  logic            rx_ready,
  output logic            rx_ovf,
  input  logic            ovf_clr,
  output logic            busy,
  input  logic            rx,
  output logic            tx
);

  // Streams: a beat transfers on any cycle where valid and ready are both high;
  // tx_ready and rx_valid never depend on the partner's valid or ready.

  logic [DIV_-1:0] div_q;
  uart_par_t       par_q;
  logic            stop2_q;
  logic [DIV_-1:0] tick_cnt;
  logic            tick;
  logic            par_en;
  logic            par_odd;

  uart_state_t      rx_state, rx_state_n;
  logic             rx_s1, rx_s2;
  logic [3:0]       rx_tcnt, rx_bcnt;
  logic [DATA_-1:0] rx_sh;
  logic             v7, v8, maj, rx_samp, rx_end;
  logic             rx_perr_q, rx_ferr_q, rx_armed, rx_stop_idx;
  logic             rx_push, rx_full, rx_empty;
  logic [DATA_+1:0] rx_wdata, rx_rdata;

  uart_state_t      tx_state, tx_state_n;
  logic [3:0]       tx_tcnt, tx_bcnt;
  logic [DATA_-1:0] tx_sh, tx_rdata;
  logic             tx_pbit, tx_stop_idx, tx_end, tx_bit, tx_q;
  logic             tx_pop, tx_full, tx_empty;

  assign tick    = (tick_cnt == '0);
  assign par_en  = (par_q != PAR_NONE);
  assign par_odd = (par_q == PAR_ODD);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q    <= DIV_'(DIV_RST);
      par_q    <= PAR_NONE;
      stop2_q  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      if (cfg_load && rx_state == ST_IDLE && tx_state == ST_IDLE) begin
        div_q   <= cfg_div;
        par_q   <= (cfg_par == 2'b11) ? PAR_NONE : uart_par_t'(cfg_par);
        stop2_q <= cfg_stop2;
      end
      tick_cnt <= tick ? div_q : tick_cnt - 1'b1;
    end
  end

  // ---------------- receiver ----------------
  assign maj     = (v7 & v8) | (v7 & rx_s2) | (v8 & rx_s2);
  assign rx_samp = tick && (rx_tcnt == SAMP_C);
  assign rx_end  = tick && (rx_tcnt == TICK_LAST);
  assign rx_wdata = {rx_ferr_q | ~maj, rx_perr_q, rx_sh};

  always_comb begin
    rx_state_n = rx_state;
    rx_push    = 1'b0;
    case (rx_state)
      ST_IDLE:   if (rx_armed && !rx_s2) rx_state_n = ST_START;
      ST_START:  begin
        if (rx_samp && maj) rx_state_n = ST_IDLE;
        else if (rx_end)    rx_state_n = ST_DATA;
      end
      ST_DATA:   if (rx_end && rx_bcnt == 4'(DATA_ - 1))
                   rx_state_n = par_en ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_end) rx_state_n = ST_STOP;
      ST_STOP:   if (rx_samp && rx_stop_idx == stop2_q) begin
        rx_push    = 1'b1;
        rx_state_n = ST_IDLE;
      end
      default:   rx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= ST_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
    end else begin
      rx_state <= rx_state_n;
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_tcnt <= '0; rx_bcnt <= '0; rx_sh <= '0;
      v7 <= 1'b1; v8 <= 1'b1;
      rx_perr_q <= 1'b0; rx_ferr_q <= 1'b0; rx_stop_idx <= 1'b0;
      rx_armed  <= 1'b1;
      rx_ovf    <= 1'b0;
    end else begin
      // A framing error disarms start detection until the line idles high again.
      if (rx_push)                          rx_armed <= ~rx_wdata[DATA_+1];
      else if (rx_state == ST_IDLE && rx_s2) rx_armed <= 1'b1;
      if (rx_state == ST_IDLE) begin
        rx_tcnt <= '0; rx_bcnt <= '0; rx_stop_idx <= 1'b0;
        rx_perr_q <= 1'b0; rx_ferr_q <= 1'b0;
      end else if (tick) begin
        rx_tcnt <= rx_end ? 4'd0 : rx_tcnt + 4'd1;
        if (rx_tcnt == SAMP_A) v7 <= rx_s2;
        if (rx_tcnt == SAMP_B) v8 <= rx_s2;
        if (rx_samp) begin
          case (rx_state)
            ST_DATA:   rx_sh     <= {maj, rx_sh[DATA_-1:1]};
            ST_PARITY: rx_perr_q <= maj ^ par_of(par_odd, ^rx_sh);
            ST_STOP:   rx_ferr_q <= rx_ferr_q | ~maj;
            default:   ;
          endcase
        end
        if (rx_end && rx_state == ST_DATA) rx_bcnt     <= rx_bcnt + 4'd1;
        if (rx_end && rx_state == ST_STOP) rx_stop_idx <= 1'b1;
      end
      if (ovf_clr)                             rx_ovf <= 1'b0;
      else if (rx_push && rx_full && !rx_ready) rx_ovf <= 1'b1;
    end
  end

  uartx_fifo #(.W(DATA_ + 2), .DEPTH_(DEPTH_)) u_rx_fifo (
    .clk(clk), .rst(rst), .wdata(rx_wdata), .push(rx_push), .full(rx_full),
    .rdata(rx_rdata), .pop(rx_ready), .empty(rx_empty)
  );

  assign {rx_ferr, rx_perr, rx_data} = rx_rdata;
  assign rx_valid = !rx_empty;

  // ---------------- transmitter ----------------
  assign tx_end = tick && (tx_tcnt == TICK_LAST);

  always_comb begin
    tx_state_n = tx_state;
    tx_pop     = 1'b0;
    tx_bit     = 1'b1;
    case (tx_state)
      ST_IDLE:   if (tick && !tx_empty) begin
        tx_pop     = 1'b1;
        tx_state_n = ST_START;
      end
      ST_START:  begin
        tx_bit = 1'b0;
        if (tx_end) tx_state_n = ST_DATA;
      end
      ST_DATA:   begin
        tx_bit = tx_sh[0];
        if (tx_end && tx_bcnt == 4'(DATA_ - 1))
          tx_state_n = par_en ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx_bit = tx_pbit;
        if (tx_end) tx_state_n = ST_STOP;
      end
      ST_STOP:   if (tx_end && tx_stop_idx == stop2_q) begin
        // Chain straight into the next start bit so frames carry no idle gap.
        tx_pop     = !tx_empty;
        tx_state_n = tx_empty ? ST_IDLE : ST_START;
      end
      default:   tx_state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= ST_IDLE;
      tx_q     <= 1'b1;
      tx_tcnt  <= '0; tx_bcnt <= '0; tx_sh <= '0;
      tx_pbit  <= 1'b0; tx_stop_idx <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_q     <= tx_bit;
      if (tx_pop) begin
        tx_sh       <= tx_rdata;
        tx_pbit     <= par_of(par_odd, ^tx_rdata);
        tx_tcnt     <= '0;
        tx_bcnt     <= '0;
        tx_stop_idx <= 1'b0;
      end else if (tick && tx_state != ST_IDLE) begin
        tx_tcnt <= tx_end ? 4'd0 : tx_tcnt + 4'd1;
        if (tx_end && tx_state == ST_DATA) begin
          tx_sh   <= tx_sh >> 1;
          tx_bcnt <= tx_bcnt + 4'd1;
        end
        if (tx_end && tx_state == ST_STOP) tx_stop_idx <= 1'b1;
      end
    end
  end

  uartx_fifo #(.W(DATA_), .DEPTH_(DEPTH_)) u_tx_fifo (
    .clk(clk), .rst(rst), .wdata(tx_data), .push(tx_valid), .full(tx_full),
    .rdata(tx_rdata), .pop(tx_pop), .empty(tx_empty)
  );

  assign tx_ready = !tx_full;
  assign tx       = tx_q;
  assign busy     = (rx_state != ST_IDLE) || (tx_state != ST_IDLE);

endmodule

// File: tb/tb_uartx.sv
// Bench for uartx: loopback and pin-driven frames, checked through an expected
// queue of {ferr, perr, data} words popped as the RX stream delivers them.
module tb_uartx;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   cfg_div = '0;
  logic [1:0]    cfg_par = '0;
  logic          cfg_stop2 = 1'b0;
  logic          cfg_load = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_perr, rx_ferr, rx_valid, rx_ready, rx_ovf, busy, tx;
  logic          ovf_clr = 1'b0;
  logic          rx_line;
  logic          loop = 1'b0;
  logic          rx_drv = 1'b1;
  logic          hold = 1'b0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int wr_cyc = 0;
  logic [DW+1:0] exp_q[$];

  assign rx_line  = loop ? tx : rx_drv;
  assign rx_ready = !hold;

  uartx dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_par(cfg_par),
    .cfg_stop2(cfg_stop2), .cfg_load(cfg_load), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .rx_ovf(rx_ovf), .ovf_clr(ovf_clr), .busy(busy),
    .rx(rx_line), .tx(tx)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      chk("rx_word_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("rx_word", {rx_ferr, rx_perr, rx_data}, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [1:0] p, input logic s2);
    cfg_div = '0; cfg_par = p; cfg_stop2 = s2; cfg_load = 1'b1;
    step(1);
    cfg_load = 1'b0;
  endtask

  task automatic send_tx(input logic [DW-1:0] b, input logic expect_rx);
    int t;
    t = 0;
    tx_data = b; tx_valid = 1'b1;
    while (!tx_ready && t < 5000) begin step(1); t++; end
    chk("tx_ready_wait", (t < 5000), 1);
    step(1);
    wr_cyc = cyc;
    tx_valid = 1'b0;
    if (expect_rx) exp_q.push_back({2'b00, b});
  endtask

  task automatic wait_fall(output int at);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 2000) begin step(1); t++; end
    chk("tx_fall_seen", tx, 0);
    at = cyc;
  endtask

  task automatic rx_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      step(16);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin step(1); t++; end
    chk("rx_drain", exp_q.size(), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f, n;
    logic [7:0] d;
    logic [7:0] b3 [3];
    logic [11:0] fr;
    b3[0] = 8'h00; b3[1] = 8'hA5; b3[2] = 8'hFF;

    step(3);
    chk("rst_tx", tx, 1);
    chk("rst_tx_ready", tx_ready, 1);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_word", {rx_ferr, rx_perr, rx_data}, 0);
    chk("rst_rx_ovf", rx_ovf, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    step(2);

    // Loopback 8N1, div 0: three back-to-back frames of 160 clocks each.
    load_cfg(2'b00, 1'b0);
    step(5);
    loop = 1'b1;
    send_tx(b3[0], 1'b1);
    wait_fall(f);
    send_tx(b3[1], 1'b1);
    send_tx(b3[2], 1'b1);
    step(f + 8 - cyc);
    for (int k = 0; k < 30; k++) begin
      d = b3[k / 10];
      if (k % 10 == 0)      chk("tx_8n1_start", tx, 0);
      else if (k % 10 == 9) chk("tx_8n1_stop", tx, 1);
      else                  chk("tx_8n1_data", tx, d[(k % 10) - 1]);
      step(16);
    end
    step(60);
    wait_drain();

    // Even parity, two stop bits: 0x07 carries parity 1.
    load_cfg(2'b01, 1'b1);
    step(5);
    send_tx(8'h07, 1'b1);
    wait_fall(f);
    chk("tx_latency_ok", ((f - wr_cyc) <= 4), 1);
    step(8);
    fr = 12'hE0E;
    for (int k = 0; k < 12; k++) begin
      chk("tx_par_frame", tx, fr[k]);
      step(16);
    end
    step(60);
    wait_drain();

    // Injected frame with the parity bit flipped.
    loop = 1'b0;
    exp_q.push_back({1'b0, 1'b1, 8'h07});
    rx_bits(16'h0C0E, 12);
    step(40);
    wait_drain();

    // Start-bit glitch of 5 ticks.
    rx_drv = 1'b0;
    step(5);
    rx_drv = 1'b1;
    step(40);
    chk("glitch_busy", busy, 0);
    chk("glitch_no_push", rx_valid, 0);

    // Line held low through the stop bit, then kept low: one ferr word only.
    load_cfg(2'b00, 1'b0);
    step(5);
    exp_q.push_back({1'b1, 1'b0, 8'h00});
    rx_drv = 1'b0;
    step(420);
    chk("ferr_single", exp_q.size(), 0);
    chk("ferr_disarmed_busy", busy, 0);
    rx_drv = 1'b1;
    step(32);
    exp_q.push_back({2'b00, 8'h3C});
    rx_bits({6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    step(40);
    wait_drain();

    // Overflow: 17 frames with the consumer stalled.
    hold = 1'b1;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back({2'b00, d});
      rx_bits({6'b0, 1'b1, d, 1'b0}, 10);
    end
    step(20);
    chk("ovf_set", rx_ovf, 1);
    chk("ovf_valid", rx_valid, 1);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", rx_ovf, 0);
    hold = 1'b0;
    wait_drain();

    // Fill the TX FIFO, then reset mid-frame during the data bits.
    step(20);
    for (int i = 0; i < 17; i++) send_tx(8'(i * 13), 1'b0);
    chk("tx_ready_full", tx_ready, 0);
    step(40);
    chk("pre_rst_tx_data", tx, 0);
    rst = 1'b1;
    step(1);
    chk("midrst_tx", tx, 1);
    chk("midrst_tx_ready", tx_ready, 1);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx == 1'b0) n++;
      step(1);
    end
    chk("midrst_tx_quiet", n, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
